// File: rtl/program_counter.sv
// Fetch-address register for the CPU front end: advances by 4 or loads a redirect target.
// Optional redirect trace outputs are compiled in when the macro PC_TRACE_EN is defined.
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned STEP         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        misaligned
`ifdef PC_TRACE_EN
  ,
  output logic        trace_valid,
  output logic [31:0] trace_src,
  output logic [31:0] trace_dst,
  output logic [31:0] redirect_count
`endif
);

  logic        accept_load;
  logic [31:0] aligned_target;
  logic [31:0] pc_next;
  logic        misaligned_next;

  assign accept_load    = en & load;
  assign aligned_target = {target[31:2], 2'b00};

  // Natural 32-bit overflow provides the 0xFFFF_FFFC -> 0x0 wrap.
  assign pc_plus_4 = pc + 32'(STEP);

  always_comb begin
    pc_next         = pc;
    misaligned_next = 1'b0;
    if (en) begin
      if (load) begin
        pc_next         = aligned_target;
        misaligned_next = (target[1:0] != 2'b00);
      end else begin
        pc_next = pc_plus_4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      pc         <= pc_next;
      misaligned <= misaligned_next;
    end
  end

`ifdef PC_TRACE_EN
  logic [31:0] count_next;

  // Saturate rather than wrap so a huge redirect count never reads as small.
  assign count_next = (redirect_count == 32'hFFFF_FFFF) ? redirect_count
                                                        : redirect_count + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid    <= 1'b0;
      trace_src      <= 32'h0000_0000;
      trace_dst      <= 32'h0000_0000;
      redirect_count <= 32'h0000_0000;
    end else begin
      trace_valid <= accept_load;
      if (accept_load) begin
        trace_src      <= pc;
        trace_dst      <= aligned_target;
        redirect_count <= count_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed test-plan sequences plus random
// en/load/target traffic compared against an arithmetic reference model.
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        misaligned;
`ifdef PC_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_src;
  logic [31:0] trace_dst;
  logic [31:0] redirect_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint unsigned exp_pc;
  bit              exp_mis;
  bit              exp_tv;
  longint unsigned exp_src;
  longint unsigned exp_dst;
  longint unsigned exp_cnt;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  program_counter #(
    .RESET_VECTOR(32'h0000_0000),
    .STEP        (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .load          (load),
    .target        (target),
    .pc            (pc),
    .pc_plus_4     (pc_plus_4),
    .misaligned    (misaligned)
`ifdef PC_TRACE_EN
    ,
    .trace_valid   (trace_valid),
    .trace_src     (trace_src),
    .trace_dst     (trace_dst),
    .redirect_count(redirect_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    exp_pc  = 0;
    exp_mis = 0;
    exp_tv  = 0;
    exp_src = 0;
    exp_dst = 0;
    exp_cnt = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " pc"}, pc, 32'(exp_pc));
    checkOutput({tag, " pc_plus_4"}, pc_plus_4, 32'((exp_pc + 4) % MOD));
    checkOutput({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, exp_mis});
`ifdef PC_TRACE_EN
    checkOutput({tag, " trace_valid"}, {31'b0, trace_valid}, {31'b0, exp_tv});
    checkOutput({tag, " trace_src"}, trace_src, 32'(exp_src));
    checkOutput({tag, " trace_dst"}, trace_dst, 32'(exp_dst));
    checkOutput({tag, " redirect_count"}, redirect_count, 32'(exp_cnt));
`endif
  endtask

  // Drive one cycle of inputs, predict the result from the rules, then compare after the edge.
  task automatic applyStimulus(input bit e, input bit l, input logic [31:0] t, input string tag);
    longint unsigned n_pc;
    bit              n_mis;
    en     = e;
    load   = l;
    target = t;
    n_pc   = exp_pc;
    n_mis  = 0;
    if (e && l) begin
      n_pc  = longint'(t) - (longint'(t) % 4);
      n_mis = (t % 4) != 0;
    end else if (e) begin
      n_pc = (exp_pc + 4) % MOD;
    end
    exp_tv = e && l;
    if (e && l) begin
      exp_src = exp_pc;
      exp_dst = n_pc;
      if (exp_cnt < MOD - 1) exp_cnt = exp_cnt + 1;
    end
    @(posedge clk);
    #1;
    exp_pc  = n_pc;
    exp_mis = n_mis;
    checkAll(tag);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    target = 32'h0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, "hold");
    applyStimulus(1'b1, 1'b0, 32'h0, "adv1");
    applyStimulus(1'b1, 1'b0, 32'h0, "adv2");
    applyStimulus(1'b1, 1'b1, 32'h00C0_FFEE, "load_mis");
    applyStimulus(1'b1, 1'b0, 32'h0, "after_mis1");
    applyStimulus(1'b1, 1'b0, 32'h0, "after_mis2");
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, "load_gated");
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, "load_100");
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, "load_same");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, "load_top");
    applyStimulus(1'b1, 1'b0, 32'h0, "wrap");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, "load_top_mis");
    applyStimulus(1'b1, 1'b0, 32'h0, "wrap2");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 9) < 2) t = {$urandom_range(0, 1) == 0 ? 30'h3FFF_FFFF : 30'(t[31:2]), 2'b00};
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, t, "rand");
    end

    // Asynchronous reset between clock edges
    applyStimulus(1'b1, 1'b1, 32'h0000_4000, "pre_rst_load");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, "post_rst_adv");
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, "post_rst_load1");
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, "post_rst_gated");
    applyStimulus(1'b1, 1'b1, 32'h0000_0302, "post_rst_load2");
    applyStimulus(1'b1, 1'b0, 32'h0, "post_rst_adv2");

    for (int i = 0; i < 100; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, "rand2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
